vc_test_nport_rand_delay_mem: RTL and testbench
===============================================

Name: vc_test_nport_rand_delay_mem

Overview:
Parametrised N-port test memory for simulation benches. It generalises the fixed three-port random-delay test memory to any port count, with per-port response queues and a per-port LFSR random response delay. Each port has its own val/rdy request and response channels. It sits beside the DUT in test harnesses, and benches preload its contents hierarchically.

Parameters:
p_num_ports, 3, number of independent request/response port pairs (1..8)
p_mem_sz, 1024, physical memory size in bytes (power of two)
p_addr_sz, 8, request address width in bits
p_data_sz, 32, data width in bits (power of two, >= 8)
p_max_delay, 0, maximum extra response delay in cycles (0 = no random delay)
p_queue_depth, 2, response queue entries per port (power of two, >= 2)
c_req_msg_sz, derived, VC mem request message width (type, addr, len, data)
c_resp_msg_sz, derived, VC mem response message width (type, len, data)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset (asserted at 0)
memreq_val  in  p_num_ports  per-port request valid
memreq_rdy  out  p_num_ports  per-port request ready
memreq_msg  in  p_num_ports*c_req_msg_sz  packed requests; port i at slice i
memresp_val  out  p_num_ports  per-port response valid
memresp_rdy  in  p_num_ports  per-port response ready
memresp_msg  out  p_num_ports*c_resp_msg_sz  packed responses; port i at slice i

Behaviour:
- Reset (async assert at reset=0, sync release): all queues empty, memreq_rdy=all 1s, memresp_val=0, memresp_msg=0, delay FSMs in IDLE, each port's LFSR loaded with seed 16'hACE1 ^ (i+1). Memory contents are not cleared.
- Request accept: memreq_rdy[i] = queue i not full. A request is taken on memreq_val[i] & memreq_rdy[i].
- Addressing: byte address modulo p_mem_sz. len=0 means the full word; otherwise len is a byte count. The access starts at byte offset addr mod (p_data_sz/8) inside the aligned word. Bytes past the end of the word are dropped.
- Read: returns the selected bytes, right-justified and zero-extended. Reads see memory state from before the current edge, so same-cycle writes are not visible.
- Write: byte-enabled update commits at the clock edge. The response data field is 0.
- Same-cycle writes to the same byte from several ports: highest port index wins.
- Response message echoes the request type and len.
- Each port has a response FIFO, written the cycle the request is accepted. Simultaneous push and pop is allowed when the queue is full.
- Per-port delay FSM:
  - IDLE: if the queue is non-empty, load cnt = lfsr mod (p_max_delay+1) and go to WAIT, or to VALID if cnt=0.
  - WAIT: decrement cnt; at 1, go to VALID.
  - VALID: memresp_val=1 with the queue head. On rdy, pop and go to IDLE.
- Each LFSR (x^16+x^14+x^13+x^11) advances every cycle.
- Minimum latency is 2 cycles from request accept to memresp_val (1 when p_max_delay=0 and the FSM is already IDLE with a pending head is not possible; the FIFO is registered).
- Back-to-back throughput is 1 response per 2 cycles per port; ports are fully independent.
- memresp_val, once high, stays high with a stable message until rdy.
- Reset mid-operation flushes queued responses. Writes already committed remain in memory.

Optional Feature:
VC_TEST_MEM_REQ_STALL_EN.
- Defined and p_max_delay>0: memreq_rdy[i] is additionally forced to 0 in any cycle where lfsr[i][0]=1, giving random request backpressure.
- Undefined, or p_max_delay=0: memreq_rdy depends only on queue fullness.

Decomposition:
- Shared package vc_test_mem_pkg: request/response field offsets and widths, type encodings (read=0, write=1), LFSR taps and seed constant, and the len-to-byte-mask function.
- Natural sub-module: vc_test_mem_resp_port, containing one port's FIFO, delay FSM and LFSR. It is instantiated p_num_ports times with a generate loop, and takes the port index as a parameter for the seed.

Test Plan:
- p_num_ports=3, p_max_delay=0: write 0xDEADBEEF to addr 0x10 on port 0, then read 0x10 on port 2 -> port 2 responds with data 0xDEADBEEF, type read, 2 cycles after accept.
- Same-cycle write to 0x20: port 0 writes 0x11111111, port 1 writes 0x22222222; then read -> 0x22222222.
- Subword: write len=1 data 0xAB at 0x23, then full-word read of 0x20 -> byte 3 = 0xAB and other bytes unchanged.
- Hold port 1 memresp_rdy=0 and issue 3 requests -> memreq_rdy[1] drops after 2 accepts. Release -> responses are returned in order, and ports 0/2 are unaffected.
- p_max_delay=4, 200 random reads per port -> every latency falls in 2..6 cycles, no response is lost or reordered, and data matches the reference model.
- Assert reset=0 mid-traffic with queues non-empty -> memresp_val=0 immediately and rdy all 1s after release. A read of an earlier-written address still returns the written data.

Source files
------------

// File: rtl/vc_test_mem_pkg.sv
// Shared definitions for the N-port random-delay test memory.
// Message layout, type codes, LFSR constants and byte-mask helper.
package vc_test_mem_pkg;

    localparam logic c_type_read  = 1'b0;
    localparam logic c_type_write = 1'b1;

    localparam logic [15:0] c_lfsr_seed = 16'hACE1;
    // Taps for x^16 + x^14 + x^13 + x^11
    localparam logic [15:0] c_lfsr_taps = 16'hB400;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_VALID
    } dly_state_e;

    function automatic int len_sz(input int data_sz);
        return (data_sz > 8) ? $clog2(data_sz / 8) : 1;
    endfunction

    // Request: {type, addr, len, data}, data in the low bits
    function automatic int req_msg_sz(input int addr_sz, input int data_sz);
        return 1 + addr_sz + len_sz(data_sz) + data_sz;
    endfunction

    // Response: {type, len, data}
    function automatic int resp_msg_sz(input int data_sz);
        return 1 + len_sz(data_sz) + data_sz;
    endfunction

    // Byte mask for an access of len bytes (0 = full word) at offset off
    function automatic logic [63:0] len_to_mask(
        input int len,
        input int off,
        input int nbytes
    );
        int          n;
        logic [63:0] m;
        n = (len == 0) ? nbytes : len;
        m = ((64'd1 << n) - 64'd1) << off;
        return m & ((64'd1 << nbytes) - 64'd1);
    endfunction

endpackage

// File: rtl/vc_test_mem_resp_port.sv
// One port's response FIFO, random-delay FSM and LFSR.
// VC_TEST_MEM_REQ_STALL_EN adds random request backpressure.
module vc_test_mem_resp_port
    import vc_test_mem_pkg::*;
#(
    parameter int p_idx       = 0,
    parameter int p_msg_sz    = 35,
    parameter int p_max_delay = 0,
    parameter int p_depth     = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                push,
    input  logic [p_msg_sz-1:0] push_msg,
    output logic                req_rdy,
    output logic                resp_val,
    input  logic                resp_rdy,
    output logic [p_msg_sz-1:0] resp_msg
);

    localparam int c_aw    = $clog2(p_depth);
    localparam int c_cnt_w = $clog2(p_max_delay + 2);

    logic [p_msg_sz-1:0] q [p_depth];
    logic [c_aw-1:0]     wr_ptr;
    logic [c_aw-1:0]     rd_ptr;
    logic [c_aw:0]       count;
    logic [15:0]         lfsr;
    logic [c_cnt_w-1:0]  cnt;
    logic [c_cnt_w-1:0]  cnt_n;
    logic [c_cnt_w-1:0]  cnt_ld;
    dly_state_e          state;
    dly_state_e          state_n;
    logic                pop;
    logic                full;
    logic                empty;

    assign full   = (count == (c_aw + 1)'(p_depth));
    assign empty  = (count == '0);
    assign cnt_ld = c_cnt_w'(lfsr % 16'(p_max_delay + 1));

`ifdef VC_TEST_MEM_REQ_STALL_EN
    assign req_rdy = !full && !((p_max_delay > 0) && lfsr[0]);
`else
    assign req_rdy = !full;
`endif

    assign resp_msg = resp_val ? q[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) q[wr_ptr] <= push_msg;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            lfsr   <= c_lfsr_seed ^ 16'(p_idx + 1);
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            lfsr   <= {lfsr[14:0], ^(lfsr & c_lfsr_taps)};
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count  <= count + {c_aw'(0), push} - {c_aw'(0), pop};
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        resp_val = 1'b0;
        pop      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!empty) begin
                    cnt_n   = cnt_ld;
                    state_n = (cnt_ld == '0) ? S_VALID : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_n = cnt - 1'b1;
                if (cnt == c_cnt_w'(1)) state_n = S_VALID;
            end
            S_VALID: begin
                resp_val = 1'b1;
                if (resp_rdy) begin
                    pop     = 1'b1;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: rtl/vc_test_nport_rand_delay_mem.sv
// N-port test memory with per-port random response delay.
// Optional VC_TEST_MEM_REQ_STALL_EN: random request backpressure.
module vc_test_nport_rand_delay_mem
    import vc_test_mem_pkg::*;
#(
    parameter int p_num_ports   = 3,
    parameter int p_mem_sz      = 1024,
    parameter int p_addr_sz     = 8,
    parameter int p_data_sz     = 32,
    parameter int p_max_delay   = 0,
    parameter int p_queue_depth = 2,
    localparam int c_req_msg_sz  = req_msg_sz(p_addr_sz, p_data_sz),
    localparam int c_resp_msg_sz = resp_msg_sz(p_data_sz)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [p_num_ports-1:0]               memreq_val,
    output logic [p_num_ports-1:0]               memreq_rdy,
    input  logic [p_num_ports*c_req_msg_sz-1:0]  memreq_msg,
    output logic [p_num_ports-1:0]               memresp_val,
    input  logic [p_num_ports-1:0]               memresp_rdy,
    output logic [p_num_ports*c_resp_msg_sz-1:0] memresp_msg
);

    localparam int c_nbytes    = p_data_sz / 8;
    localparam int c_len_sz    = len_sz(p_data_sz);
    localparam int c_num_words = p_mem_sz / c_nbytes;
    localparam int c_widx_w    = $clog2(c_num_words);
    localparam logic [p_data_sz-1:0] c_ones = '1;

    logic [p_data_sz-1:0]     mem [c_num_words];
    logic                     req_typ  [p_num_ports];
    logic [p_addr_sz-1:0]     req_addr [p_num_ports];
    logic [c_len_sz-1:0]      req_len  [p_num_ports];
    logic [p_data_sz-1:0]     req_data [p_num_ports];
    logic [c_widx_w-1:0]      widx     [p_num_ports];
    logic [c_nbytes-1:0]      wen      [p_num_ports];
    logic [p_data_sz-1:0]     wsh      [p_num_ports];
    logic [c_resp_msg_sz-1:0] resp_in  [p_num_ports];
    logic [p_num_ports-1:0]   push;

    assign push = memreq_val & memreq_rdy;

    always_comb begin
        int                   baddr;
        int                   off;
        int                   nb;
        logic [p_data_sz-1:0] rword;
        logic [p_data_sz-1:0] rdata;
        baddr = 0;
        off   = 0;
        nb    = 0;
        rword = '0;
        rdata = '0;
        for (int i = 0; i < p_num_ports; i++) begin
            req_typ[i]  = memreq_msg[i*c_req_msg_sz + c_req_msg_sz - 1];
            req_addr[i] = memreq_msg[i*c_req_msg_sz + p_data_sz + c_len_sz +: p_addr_sz];
            req_len[i]  = memreq_msg[i*c_req_msg_sz + p_data_sz +: c_len_sz];
            req_data[i] = memreq_msg[i*c_req_msg_sz +: p_data_sz];
            baddr   = int'(req_addr[i]) % p_mem_sz;
            off     = baddr % c_nbytes;
            nb      = (req_len[i] == '0) ? c_nbytes : int'(req_len[i]);
            widx[i] = c_widx_w'(baddr / c_nbytes);
            wen[i]  = c_nbytes'(len_to_mask(int'(req_len[i]), off, c_nbytes));
            wsh[i]  = req_data[i] << (8 * off);
            // Shifting right drops bytes that would fall past the word end
            rword   = mem[widx[i]] >> (8 * off);
            rdata   = rword & (c_ones >> (8 * (c_nbytes - nb)));
            if (req_typ[i] == c_type_write) rdata = '0;
            resp_in[i] = {req_typ[i], req_len[i], rdata};
        end
    end

    // Later ports overwrite earlier ones on byte collisions
    always_ff @(posedge clk) begin
        for (int i = 0; i < p_num_ports; i++) begin
            if (push[i] && req_typ[i] == c_type_write) begin
                for (int b = 0; b < c_nbytes; b++) begin
                    if (wen[i][b]) mem[widx[i]][8*b +: 8] <= wsh[i][8*b +: 8];
                end
            end
        end
    end

    for (genvar i = 0; i < p_num_ports; i++) begin : g_port
        vc_test_mem_resp_port #(
            .p_idx       (i),
            .p_msg_sz    (c_resp_msg_sz),
            .p_max_delay (p_max_delay),
            .p_depth     (p_queue_depth)
        ) u_port (
            .clk      (clk),
            .reset    (reset),
            .push     (push[i]),
            .push_msg (resp_in[i]),
            .req_rdy  (memreq_rdy[i]),
            .resp_val (memresp_val[i]),
            .resp_rdy (memresp_rdy[i]),
            .resp_msg (memresp_msg[i*c_resp_msg_sz +: c_resp_msg_sz])
        );
    end

endmodule

// File: tb/tb_vc_test_nport_rand_delay_mem.sv
// Bench for vc_test_nport_rand_delay_mem: directed steps on a
// zero-delay instance, random reads on a max-delay-4 instance.
module tb_vc_test_nport_rand_delay_mem;

    localparam int RQ = 43;
    localparam int RS = 35;

    typedef struct {
        logic [RS-1:0] msg;
        int            acc;
        int            lo;
        int            hi;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst0, rst1;
    logic [2:0]      qv0, qr0, sv0, sr0;
    logic [2:0]      qv1, qr1, sv1, sr1;
    logic [3*RQ-1:0] qm0, qm1;
    logic [3*RS-1:0] sm0, sm1;

    vc_test_nport_rand_delay_mem #(.p_num_ports(3), .p_max_delay(0)) dut0 (
        .clk(clk), .reset(rst0),
        .memreq_val(qv0), .memreq_rdy(qr0), .memreq_msg(qm0),
        .memresp_val(sv0), .memresp_rdy(sr0), .memresp_msg(sm0)
    );

    vc_test_nport_rand_delay_mem #(.p_num_ports(3), .p_max_delay(4)) dut1 (
        .clk(clk), .reset(rst1),
        .memreq_val(qv1), .memreq_rdy(qr1), .memreq_msg(qm1),
        .memresp_val(sv1), .memresp_rdy(sr1), .memresp_msg(sm1)
    );

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    exp_t sb [2][3][$];
    int   lo [2][3];
    int   hi [2][3];
    int   seen [2][3];
    int   lat [2][3];
    logic [7:0] model [2][256];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mon(input int d, input logic [2:0] qv, input logic [2:0] qr,
                       input logic [3*RQ-1:0] qm, input logic [2:0] sv,
                       input logic [2:0] sr, input logic [3*RS-1:0] sm);
        exp_t          e;
        logic          typ [3];
        logic [7:0]    a [3];
        logic [1:0]    ln [3];
        logic [31:0]   dat [3];
        logic [31:0]   rd;
        int            off, n;
        for (int p = 0; p < 3; p++) begin
            if (sv[p]) begin
                if (sb[d][p].size() == 0) begin
                    chk($sformatf("spurious_val_d%0d_p%0d", d, p), 64'(sv[p]), 0);
                end else begin
                    e = sb[d][p][0];
                    if (seen[d][p] == 0) begin
                        seen[d][p] = 1;
                        lat[d][p] = cyc - e.acc;
                    end
                    if (sr[p]) begin
                        chk($sformatf("resp_d%0d_p%0d", d, p), 64'(sm[p*RS +: RS]), 64'(e.msg));
                        total++;
                        assert (lat[d][p] >= e.lo && lat[d][p] <= e.hi) else begin
                            bad++;
                            $error("FAIL latency_d%0d_p%0d observed=%0d expected=%0d..%0d",
                                   d, p, lat[d][p], e.lo, e.hi);
                        end
                        void'(sb[d][p].pop_front());
                        seen[d][p] = 0;
                    end
                end
            end
        end
        for (int p = 0; p < 3; p++) begin
            {typ[p], a[p], ln[p], dat[p]} = qm[p*RQ +: RQ];
            if (qv[p] && qr[p]) begin
                off = int'(a[p]) % 4;
                n = (ln[p] == 0) ? 4 : int'(ln[p]);
                rd = '0;
                for (int b = 0; b < n; b++)
                    if (off + b < 4) rd[8*b +: 8] = model[d][int'(a[p]) + b];
                e.msg = {typ[p], ln[p], typ[p] ? 32'h0 : rd};
                e.acc = cyc;
                e.lo = lo[d][p];
                e.hi = hi[d][p];
                sb[d][p].push_back(e);
            end
        end
        for (int p = 0; p < 3; p++) begin
            if (qv[p] && qr[p] && typ[p]) begin
                off = int'(a[p]) % 4;
                n = (ln[p] == 0) ? 4 : int'(ln[p]);
                for (int b = 0; b < n; b++)
                    if (off + b < 4) model[d][int'(a[p]) + b] = dat[p][8*b +: 8];
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst0) mon(0, qv0, qr0, qm0, sv0, sr0, sm0);
        if (rst1) mon(1, qv1, qr1, qm1, sv1, sr1, sm1);
    end

    task automatic set_req(input int d, input int p, input logic typ,
                           input logic [7:0] a, input logic [1:0] ln, input logic [31:0] dat);
        if (d == 0) begin
            qm0[p*RQ +: RQ] = {typ, a, ln, dat};
            qv0[p] = 1'b1;
        end else begin
            qm1[p*RQ +: RQ] = {typ, a, ln, dat};
            qv1[p] = 1'b1;
        end
    endtask

    task automatic issue(input int d, input int p, input logic typ,
                         input logic [7:0] a, input logic [1:0] ln, input logic [31:0] dat);
        logic ok;
        ok = 1'b0;
        set_req(d, p, typ, a, ln, dat);
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            ok = (d == 0) ? qr0[p] : qr1[p];
        end
        @(posedge clk);
        #1;
        if (d == 0) qv0[p] = 1'b0; else qv1[p] = 1'b0;
        chk($sformatf("accept_d%0d_p%0d", d, p), 64'(ok), 1);
    endtask

    task automatic wait_idle(input int d, input int bound);
        int sz;
        sz = 1;
        for (int k = 0; k < bound && sz != 0; k++) begin
            @(posedge clk);
            sz = 0;
            for (int p = 0; p < 3; p++) sz += sb[d][p].size();
        end
        chk($sformatf("drain_d%0d", d), 64'(sz), 0);
        #1;
    endtask

    task automatic flush(input int d);
        for (int p = 0; p < 3; p++) begin
            sb[d][p].delete();
            seen[d][p] = 0;
        end
    endtask

    initial begin
        int   issued [3];
        logic acc [3];
        logic ok;
        int   sum;
        qv0 = '0; qv1 = '0; qm0 = '0; qm1 = '0;
        sr0 = 3'b111; sr1 = 3'b111;
        rst0 = 1'b0; rst1 = 1'b0;
        for (int p = 0; p < 3; p++) begin
            lo[0][p] = 2; hi[0][p] = 2;
            lo[1][p] = 2; hi[1][p] = 1000;
            seen[0][p] = 0; seen[1][p] = 0;
            issued[p] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rdy", 64'(qr0), 3'b111);
        chk("reset_val", 64'(sv0), 0);
        chk("reset_msg", 64'(sm0), 0);
        rst0 = 1'b1; rst1 = 1'b1;

        // Write on port 0, read back on port 2
        issue(0, 0, 1'b1, 8'h10, 2'd0, 32'hDEADBEEF);
        wait_idle(0, 50);
        issue(0, 2, 1'b0, 8'h10, 2'd0, 32'h0);
        wait_idle(0, 50);

        // Same-cycle collision, higher port wins
        set_req(0, 0, 1'b1, 8'h20, 2'd0, 32'h11111111);
        set_req(0, 1, 1'b1, 8'h20, 2'd0, 32'h22222222);
        @(posedge clk);
        #1;
        qv0 = '0;
        wait_idle(0, 50);
        issue(0, 0, 1'b0, 8'h20, 2'd0, 32'h0);
        wait_idle(0, 50);

        // Subword accesses and end-of-word truncation
        issue(0, 1, 1'b1, 8'h23, 2'd1, 32'h000000AB);
        issue(0, 0, 1'b0, 8'h20, 2'd0, 32'h0);
        issue(0, 2, 1'b0, 8'h23, 2'd1, 32'h0);
        issue(0, 1, 1'b0, 8'h22, 2'd0, 32'h0);
        issue(0, 0, 1'b0, 8'h21, 2'd2, 32'h0);
        wait_idle(0, 50);
        issue(0, 0, 1'b1, 8'h2C, 2'd0, 32'h55555555);
        issue(0, 1, 1'b1, 8'h30, 2'd0, 32'h66666666);
        wait_idle(0, 50);
        issue(0, 2, 1'b1, 8'h2E, 2'd3, 32'h00CCBBAA);
        wait_idle(0, 50);
        issue(0, 0, 1'b0, 8'h2C, 2'd0, 32'h0);
        issue(0, 1, 1'b0, 8'h30, 2'd0, 32'h0);
        wait_idle(0, 50);

        // Backpressure on port 1 only
        sr0[1] = 1'b0;
        hi[0][1] = 100;
        issue(0, 1, 1'b0, 8'h10, 2'd0, 32'h0);
        issue(0, 1, 1'b0, 8'h20, 2'd0, 32'h0);
        set_req(0, 1, 1'b0, 8'h2C, 2'd0, 32'h0);
        issue(0, 0, 1'b0, 8'h30, 2'd0, 32'h0);
        issue(0, 2, 1'b0, 8'h23, 2'd1, 32'h0);
        @(negedge clk);
        chk("full_rdy", 64'(qr0), 3'b101);
        repeat (3) @(negedge clk);
        chk("full_rdy_hold", 64'(qr0), 3'b101);
        @(posedge clk);
        #1;
        sr0[1] = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            ok = qr0[1];
        end
        @(posedge clk);
        #1;
        qv0[1] = 1'b0;
        chk("accept_after_release", 64'(ok), 1);
        wait_idle(0, 50);

        // Reset with port 1 queue full
        sr0[1] = 1'b0;
        issue(0, 1, 1'b0, 8'h10, 2'd0, 32'h0);
        issue(0, 1, 1'b0, 8'h20, 2'd0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("pre_reset_val", 64'(sv0[1]), 1);
        chk("pre_reset_rdy", 64'(qr0), 3'b101);
        #2;
        rst0 = 1'b0;
        #1;
        flush(0);
        chk("mid_reset_val", 64'(sv0), 0);
        chk("mid_reset_msg", 64'(sm0), 0);
        chk("mid_reset_rdy", 64'(qr0), 3'b111);
        sr0[1] = 1'b1;
        @(posedge clk);
        #1;
        rst0 = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_val", 64'(sv0), 0);
        chk("post_reset_rdy", 64'(qr0), 3'b111);
        hi[0][1] = 2;
        issue(0, 1, 1'b0, 8'h10, 2'd0, 32'h0);
        issue(0, 2, 1'b0, 8'h23, 2'd1, 32'h0);
        wait_idle(0, 50);

        // Random-delay instance: fill, then random reads
        for (int w = 0; w < 64; w++)
            issue(1, w % 3, 1'b1, 8'(w * 4), 2'd0, $urandom);
        wait_idle(1, 1000);
        for (int p = 0; p < 3; p++) hi[1][p] = 6;
        sum = 0;
        for (int c = 0; c < 20000 && sum < 600; c++) begin
            @(negedge clk);
            for (int p = 0; p < 3; p++) acc[p] = qv1[p] & qr1[p];
            @(posedge clk);
            #1;
            for (int p = 0; p < 3; p++) begin
                if (acc[p]) begin
                    qv1[p] = 1'b0;
                end else if (!qv1[p] && sb[1][p].size() == 0 && issued[p] < 200) begin
                    set_req(1, p, 1'b0, 8'($urandom_range(0, 255)),
                            2'($urandom_range(0, 3)), 32'h0);
                    issued[p]++;
                end
            end
            sum = 0;
            for (int p = 0; p < 3; p++) if (issued[p] == 200 && !qv1[p]) sum += 200;
        end
        chk("random_issued", 64'(sum), 600);
        wait_idle(1, 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
